// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract unit: one shared full-adder cell walks both operands
// LSB-first, one bit per clock, with a carry flip-flop closing the loop.

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic y,
  output logic co
);
  assign y  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_y_s;
  logic             fa_co_s;

  fa u_fa (
    .a  (a_sr_r[0]),
    .b  (b_sr_r[0]),
    .ci (carry_r),
    .y  (fa_y_s),
    .co (fa_co_s)
  );

  // Next-state decode and datapath strobes
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_BIT) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; busy/done registered from next state so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN) || (state_s == DONE);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand/result shifters; subtraction is a + ~b + 1 with the +1 as initial carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_sr_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (load_s) begin
      a_sr_r  <= a;
      b_sr_r  <= sub ? ~b : b;
      carry_r <= sub;
      cnt_r   <= '0;
    end else if (step_s) begin
      a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
      res_sr_r <= {fa_y_s, res_sr_r[WIDTH-1:1]};
      carry_r  <= fa_co_s;
      cnt_r    <= cnt_r + CW'(1);
    end
  end

  // Result capture at the MSB step; carry_r here is the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_s) begin
      sum_r  <= {fa_y_s, res_sr_r[WIDTH-1:1]};
      cout_r <= fa_co_s;
      ovf_r  <= carry_r ^ fa_co_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases, start-ignore,
// mid-op reset, and randomized back-to-back operations against an arithmetic model.

module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks;
  int errors;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;
  logic             held_ovf;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic sv, output logic [WIDTH-1:0] s,
                                output logic c, output logic o);
    int ua, ub, sa, sb, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      s  = WIDTH'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      s  = WIDTH'(ua + ub);
      c  = ((ua + ub) >= (1 << WIDTH));
      sr = sa + sb;
    end
    o = (sr > ((1 << (WIDTH - 1)) - 1)) || (sr < -(1 << (WIDTH - 1)));
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done drops
  task automatic do_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic sv, input bit inj_run, input bit inj_done);
    logic [WIDTH-1:0] es;
    logic ec, eo;
    int lat;
    model(av, bv, sv, es, ec, eo);
    start = 1'b1; a = av; b = bv; sub = sv;
    @(negedge clk);
    check({tag, " busy_on"}, busy, 1'b1);
    check({tag, " sum_hold"}, {held_ovf, held_cout, sum}, {held_ovf, held_cout, held_sum});
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!done && lat < 3 * WIDTH) begin
      start = (inj_run && lat == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, WIDTH);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, ovf, eo);
    check({tag, " busy_done"}, busy, 1'b1);
    start = inj_done;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse"}, done, 1'b0);
    check({tag, " busy_off"}, busy, 1'b0);
    held_sum = es; held_cout = ec; held_ovf = eo;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic rs;
    int seen_done;
    checks = 0; errors = 0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset", {busy, done, cout, ovf, sum}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    // Random operands sit on a/b/sub while start pulses in RUN and DONE
    do_op("ignore_start", 8'h35, 8'h4A, 1'b0, 1'b1, 1'b1);
    do_op("after_ignore", 8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0);

    // Abort mid-operation with an asynchronous reset
    start = 1'b1; a = 8'h35; b = 8'h4A; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {busy, done, cout, ovf, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("rst_no_done", seen_done, 0);
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    do_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op("rand", ra, rb, rs, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
